// File: rtl/out_port_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : out_port_sched_if
// Description : Request/grant/credit bundle between requesters and the
//               output-port scheduler.
// Revision    : 1.0
// ============================================================================
interface out_port_sched_if #(
  parameter int PORT = 4
);
  logic [PORT:0] req;
  logic [PORT:0] tail;
  logic          crd_ret;
  logic [PORT:0] grt;
  logic          xfer;
  logic [3:0]    crd_cnt;
  logic          busy;
  logic          crd_err;

  modport master (
    output req, tail, crd_ret,
    input  grt, xfer, crd_cnt, busy, crd_err
  );

  modport slave (
    input  req, tail, crd_ret,
    output grt, xfer, crd_cnt, busy, crd_err
  );
endinterface
`default_nettype wire

// File: rtl/out_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : out_port_sched
// Description : Round-robin wormhole scheduler for one output port with
//               credit-based downstream flow control.
// Revision    : 1.0
// ============================================================================
module out_port_sched #(
  parameter int PORT    = 4,
  parameter int CREDITS = 4
) (
  input  logic               clk,
  input  logic               rst_,
  out_port_sched_if.slave    bus
);

  localparam int            c_n       = PORT + 1;
  localparam int            c_iw      = (PORT > 0) ? $clog2(PORT + 1) : 1;
  localparam logic [3:0]    c_credits = 4'(CREDITS);
  localparam logic [c_iw-1:0] c_last  = c_iw'(PORT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t          r_state;
  logic [PORT:0]   r_grt;
  logic [c_iw-1:0] r_ptr;
  logic [c_iw-1:0] r_own;
  logic [3:0]      r_crd;
  logic            r_busy;
  logic            r_err;

  logic [c_iw-1:0] w_pick;
  logic            w_any;
  logic            w_xfer;
  logic            w_tail_xfer;
  logic [3:0]      w_crd_nxt;
  logic            w_ovf;

  // Walk from the farthest candidate back to ptr+1 so the nearest set bit wins.
  always_comb begin
    int              s;
    logic [c_iw-1:0] sel;
    s      = 0;
    sel    = '0;
    w_pick = r_ptr;
    for (int k = c_n; k >= 1; k--) begin
      s = int'(r_ptr) + k;
      if (s >= c_n) s = s - c_n;
      sel = c_iw'(s);
      if (bus.req[sel]) w_pick = sel;
    end
  end

  assign w_any       = |bus.req;
  assign w_xfer      = (r_state == ST_LOCK) && (|(bus.req & r_grt)) && (r_crd != 4'd0);
  assign w_tail_xfer = w_xfer && (|(bus.tail & r_grt));

  always_comb begin
    w_crd_nxt = r_crd;
    w_ovf     = 1'b0;
    unique case ({w_xfer, bus.crd_ret})
      2'b10: w_crd_nxt = r_crd - 4'd1;
      2'b01: begin
        if (r_crd == c_credits) w_ovf = 1'b1;
        else                    w_crd_nxt = r_crd + 4'd1;
      end
      default: w_crd_nxt = r_crd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= ST_IDLE;
      r_grt   <= '0;
      r_ptr   <= c_last;
      r_own   <= '0;
      r_crd   <= c_credits;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_crd <= w_crd_nxt;
      if (w_ovf) r_err <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_LOCK;
            r_grt   <= {{PORT{1'b0}}, 1'b1} << w_pick;
            r_own   <= w_pick;
            r_busy  <= 1'b1;
          end
        end
        ST_LOCK: begin
          // Lock is held across req gaps until the tail flit actually moves.
          if (w_tail_xfer) begin
            r_state <= ST_IDLE;
            r_grt   <= '0;
            r_ptr   <= r_own;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grt     = r_grt;
  assign bus.xfer    = w_xfer;
  assign bus.crd_cnt = r_crd;
  assign bus.busy    = r_busy;
  assign bus.crd_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_out_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_out_port_sched
// Description : Directed vector bench for out_port_sched.
// Revision    : 1.0
// ============================================================================
module tb_out_port_sched;

  localparam int PORT    = 4;
  localparam int CREDITS = 4;

  logic clk  = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  out_port_sched_if #(.PORT(PORT)) bus ();

  out_port_sched #(.PORT(PORT), .CREDITS(CREDITS)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  typedef struct {
    logic [4:0] req;
    logic [4:0] tail;
    logic       cr;
    logic       rst;
    logic [4:0] grt;
    logic       xfer;
    logic [3:0] cnt;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input logic [4:0] req, input logic [4:0] tail, input logic cr,
                     input logic rst, input logic [4:0] grt, input logic xfer,
                     input logic [3:0] cnt, input logic busy, input logic err);
    vec_t v;
    v.req = req; v.tail = tail; v.cr = cr; v.rst = rst;
    v.grt = grt; v.xfer = xfer; v.cnt = cnt; v.busy = busy; v.err = err;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  initial begin
    int got;
    bus.req = '0; bus.tail = '0; bus.crd_ret = 1'b0;

    //   req       tail     cr rst  grt      x  cnt b  e
    add(5'b00000, 5'b00000, 0, 0, 5'b00000, 0, 4, 0, 0); // 0 reset state
    add(5'b10100, 5'b00000, 0, 1, 5'b00000, 0, 4, 0, 0); // 1 arbitrate -> 2
    add(5'b10100, 5'b00000, 0, 1, 5'b00100, 1, 4, 1, 0); // 2
    add(5'b10100, 5'b00000, 0, 1, 5'b00100, 1, 3, 1, 0); // 3
    add(5'b10100, 5'b00100, 0, 1, 5'b00100, 1, 2, 1, 0); // 4 tail
    add(5'b10100, 5'b00000, 0, 1, 5'b00000, 0, 1, 0, 0); // 5 bubble -> 4
    add(5'b10000, 5'b10000, 1, 1, 5'b10000, 1, 1, 1, 0); // 6 xfer+ret hold
    add(5'b11111, 5'b11111, 0, 1, 5'b00000, 0, 1, 0, 0); // 7 rotation
    add(5'b11111, 5'b11111, 1, 1, 5'b00001, 1, 1, 1, 0);
    add(5'b11111, 5'b11111, 0, 1, 5'b00000, 0, 1, 0, 0);
    add(5'b11111, 5'b11111, 1, 1, 5'b00010, 1, 1, 1, 0);
    add(5'b11111, 5'b11111, 0, 1, 5'b00000, 0, 1, 0, 0);
    add(5'b11111, 5'b11111, 1, 1, 5'b00100, 1, 1, 1, 0);
    add(5'b11111, 5'b11111, 0, 1, 5'b00000, 0, 1, 0, 0);
    add(5'b11111, 5'b11111, 1, 1, 5'b01000, 1, 1, 1, 0);
    add(5'b11111, 5'b11111, 0, 1, 5'b00000, 0, 1, 0, 0);
    add(5'b11111, 5'b11111, 1, 1, 5'b10000, 1, 1, 1, 0);
    add(5'b11111, 5'b11111, 0, 1, 5'b00000, 0, 1, 0, 0);
    add(5'b11111, 5'b11111, 1, 1, 5'b00001, 1, 1, 1, 0); // 18 wrap to 0
    add(5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 1, 0, 0); // 19 refill
    add(5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 2, 0, 0);
    add(5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 3, 0, 0);
    add(5'b00010, 5'b00000, 0, 1, 5'b00000, 0, 4, 0, 0); // 22 arbitrate -> 1
    add(5'b00010, 5'b00000, 0, 1, 5'b00010, 1, 4, 1, 0);
    add(5'b01001, 5'b00000, 0, 1, 5'b00010, 0, 3, 1, 0); // 24 owner gap
    add(5'b00010, 5'b00000, 0, 1, 5'b00010, 1, 3, 1, 0);
    add(5'b00010, 5'b00000, 0, 1, 5'b00010, 1, 2, 1, 0);
    add(5'b00010, 5'b00000, 0, 1, 5'b00010, 1, 1, 1, 0);
    add(5'b00010, 5'b00000, 0, 1, 5'b00010, 0, 0, 1, 0); // 28 starved
    add(5'b00010, 5'b00000, 1, 1, 5'b00010, 0, 0, 1, 0); // 29 ret lands next
    add(5'b00010, 5'b00010, 0, 1, 5'b00010, 1, 1, 1, 0); // 30 resume, tail
    add(5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 0, 0, 0);
    add(5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 1, 0, 0);
    add(5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 2, 0, 0);
    add(5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 3, 0, 0);
    add(5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 4, 0, 0); // 35 overflow
    add(5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 4, 0, 1); // 36 sticky
    add(5'b00001, 5'b00000, 0, 1, 5'b00000, 0, 4, 0, 1); // 37 arbitrate -> 0
    add(5'b00001, 5'b00000, 1, 1, 5'b00001, 1, 4, 1, 1); // 38 xfer+ret
    add(5'b00001, 5'b00000, 0, 1, 5'b00001, 1, 4, 1, 1);
    add(5'b00001, 5'b00000, 0, 1, 5'b00001, 1, 3, 1, 1);
    add(5'b00001, 5'b00000, 0, 0, 5'b00000, 0, 4, 0, 0); // 41 async reset in lock
    add(5'b00001, 5'b00000, 0, 1, 5'b00000, 0, 4, 0, 0);
    add(5'b00001, 5'b00001, 0, 1, 5'b00001, 1, 4, 1, 0); // 43

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      bus.req     = tbl[i].req;
      bus.tail    = tbl[i].tail;
      bus.crd_ret = tbl[i].cr;
      rst_        = tbl[i].rst;
      #1;
      check("grt",     i, 32'(bus.grt),     32'(tbl[i].grt));
      check("xfer",    i, 32'(bus.xfer),    32'(tbl[i].xfer));
      check("crd_cnt", i, 32'(bus.crd_cnt), 32'(tbl[i].cnt));
      check("busy",    i, 32'(bus.busy),    32'(tbl[i].busy));
      check("crd_err", i, 32'(bus.crd_err), 32'(tbl[i].err));
    end

    // Reset landing mid-cycle while locked must drop everything at once.
    @(negedge clk);
    bus.req = 5'b00100; bus.tail = '0; bus.crd_ret = 1'b0;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (bus.busy) begin
        got = 1;
        break;
      end
    end
    check("lock_wait", 100, 32'(got), 32'd1);
    check("lock_grt",  100, 32'(bus.grt), 32'(5'b00100));
    @(posedge clk); #2;
    rst_ = 1'b0;
    #1;
    check("arst_grt",  101, 32'(bus.grt),     32'd0);
    check("arst_busy", 101, 32'(bus.busy),    32'd0);
    check("arst_xfer", 101, 32'(bus.xfer),    32'd0);
    check("arst_cnt",  101, 32'(bus.crd_cnt), 32'd4);
    bus.req = 5'b01000;
    @(negedge clk); #1;
    check("rst_xfer",  102, 32'(bus.xfer),    32'd0);
    rst_ = 1'b1;
    @(posedge clk); #1;
    check("first_arb", 103, 32'(bus.grt),     32'(5'b01000));
    check("first_bsy", 103, 32'(bus.busy),    32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/out_port_sched.md
OUT_PORT_SCHED -- requirements
Module: out_port_sched

Interface
REQ-001 Parameter: PORT, 4, highest requester index; the block SHALL serve PORT+1 requesters.
REQ-002 Parameter: CREDITS, 4, downstream buffer depth in flits, legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst_  input  1  reset; asynchronous, active-low.
REQ-005 Port: req  input  PORT+1  requester i has a flit pending for this output port.
REQ-006 Port: tail  input  PORT+1  pending flit of requester i is the packet tail; valid only with req[i].
REQ-007 Port: crd_ret  input  1  downstream returns one credit this cycle.
REQ-008 Port: grt  output  PORT+1  registered one-hot grant; all-zero when no owner.
REQ-009 Port: xfer  output  1  combinational; a flit of the granted requester moves this cycle.
REQ-010 Port: crd_cnt  output  4  registered count of available downstream credits.
REQ-011 Port: busy  output  1  registered; high while in LOCK.
REQ-012 Port: crd_err  output  1  registered sticky credit-overflow flag.

Function
REQ-013 FSM SHALL have two states: IDLE (no owner) and LOCK (one owner, grt one-hot).
REQ-014 Register ptr (last served index) SHALL define round-robin order: search ptr+1, ptr+2, ... modulo PORT+1.
REQ-015 In IDLE with any req bit set, the first set bit in search order SHALL be captured; next cycle the state SHALL be LOCK with grt one-hot at that index.
REQ-016 In IDLE with req all-zero, the state, grt and ptr SHALL hold.
REQ-017 Grant latency SHALL be exactly one cycle from req sampled in IDLE to grt asserted.
REQ-018 In LOCK with owner g, xfer SHALL equal req[g] AND (crd_cnt != 0).
REQ-019 In IDLE, xfer SHALL be 0.
REQ-020 In LOCK, grt SHALL not change until a tail transfer; req[g] dropping mid-packet SHALL hold the lock (wormhole).
REQ-021 On xfer with tail[g]=1, the next state SHALL be IDLE, grt SHALL clear the next cycle, and ptr SHALL load g.
REQ-022 After a tail transfer, re-arbitration SHALL occur in the IDLE cycle that follows (one bubble cycle per packet).
REQ-023 Requests from non-owners in LOCK SHALL be ignored without being lost; they are arbitrated in the next IDLE.
REQ-024 crd_cnt SHALL decrement by 1 on xfer only, increment by 1 on crd_ret only, and hold when both or neither occur.
REQ-025 When crd_cnt is 0, xfer SHALL be 0 and the lock SHALL hold; a crd_ret in that cycle takes effect the next cycle.
REQ-026 A crd_ret without xfer while crd_cnt == CREDITS SHALL leave crd_cnt at CREDITS and set crd_err.
REQ-027 Once set, crd_err SHALL stay high until reset.
REQ-028 busy SHALL equal (state == LOCK).

Reset
REQ-029 On rst_ low, asynchronously: state=IDLE, grt=0, busy=0, ptr=PORT (so the first search starts at index 0), crd_cnt=CREDITS, crd_err=0.
REQ-030 Reset asserted mid-packet SHALL drop the lock immediately; no transfer SHALL be indicated while rst_ is low.
REQ-031 After rst_ rises, the first arbitration SHALL occur on the first rising clock edge.

Verification
REQ-032 Reset, then req=5'b10100 -> next cycle grt=5'b00100, busy=1, crd_cnt=4.
REQ-033 Owner 2 sends a 3-flit packet (tail on the 3rd flit) while req=5'b10100 is held and there is no crd_ret -> xfer high 3 cycles, crd_cnt 4->1, one IDLE cycle, then grt=5'b10000.
REQ-034 req=5'b11111 held with every flit a tail and credits replenished each cycle -> grants rotate 0,1,2,3,4,0 with one bubble between grants.
REQ-035 Owner 1 sends 4 non-tail flits with no crd_ret -> crd_cnt=0, xfer=0, grt holds 5'b00010; one crd_ret -> xfer resumes the cycle after.
REQ-036 crd_ret pulsed while crd_cnt=4 and idle -> crd_cnt stays 4, crd_err=1 and stays 1; xfer and crd_ret in the same cycle -> crd_cnt unchanged.
REQ-037 rst_ pulsed low while in LOCK with crd_cnt=2 -> immediately grt=0, busy=0, crd_cnt=4; with req=5'b00001 after release -> grt=5'b00001.
